// File: rtl/sdrc_wb_bist.sv
// rtl/sdrc_wb_bist.sv - Wishbone BIST traffic engine: LFSR burst write, readback compare, status.
// Optional ack watchdog enabled by defining SDRC_BIST_TIMEOUT_EN.
module sdrc_wb_bist #(
    parameter int dw         = 32,
    parameter int GAP_CYCLES = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic               wb_clk_i,
    input  logic               wb_resetn,
    input  logic               bist_start,
    input  logic               sdr_init_done,
    input  logic [29:0]        cfg_start_addr,
    input  logic [29:0]        cfg_addr_stride,
    input  logic [4:0]         cfg_burst_len,
    input  logic [7:0]         cfg_num_bursts,
    input  logic [31:0]        cfg_seed,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [29:0]        wb_addr_o,
    output logic [dw-1:0]      wb_dat_o,
    output logic [dw/8-1:0]    wb_sel_o,
    output logic [2:0]         wb_cti_o,
    input  logic               wb_ack_i,
    input  logic [dw-1:0]      wb_dat_i,
    output logic               bist_busy,
    output logic               bist_done,
    output logic               bist_pass,
    output logic [15:0]        bist_err_cnt,
    output logic [29:0]        bist_err_addr,
    output logic               bist_timeout
);

    localparam logic [31:0] POLY = 32'h80200003;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_INIT, S_WR, S_GAP, S_RD, S_NEXT, S_FIN
    } state_t;

    state_t      state, state_nxt;
    logic [29:0] addr, burst_addr, stride;
    logic [31:0] lfsr, lfsr_save, lfsr_next;
    logic [4:0]  burst_len, beat_left;
    logic [7:0]  burst_cnt;
    logic [15:0] gap_cnt;
    logic        beat_ack, last_beat, gap_last, wd_expire;

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ ({32{lfsr[0]}} & POLY);
    assign beat_ack  = wb_stb_o & wb_ack_i;
    assign last_beat = (beat_left == 5'd1);
    assign gap_last  = (gap_cnt == 16'(GAP_CYCLES - 1));

    // Bus outputs decode straight from state so an async reset drops the cycle at once
    assign wb_cyc_o  = (state == S_WR) || (state == S_RD);
    assign wb_stb_o  = wb_cyc_o;
    assign wb_we_o   = (state == S_WR);
    assign wb_addr_o = addr;
    assign wb_dat_o  = wb_we_o ? lfsr : '0;
    assign wb_sel_o  = wb_stb_o ? '1 : '0;
    assign wb_cti_o  = 3'b000;

`ifdef SDRC_BIST_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt;
    logic           timeout_q;

    assign wd_expire    = wb_stb_o && !wb_ack_i && (wd_cnt == WDW'(TIMEOUT - 1));
    assign bist_timeout = timeout_q;

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!wb_stb_o || wb_ack_i)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
            if (state == S_IDLE && bist_start)
                timeout_q <= 1'b0;
            else if (wd_expire)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wd_expire    = 1'b0;
    assign bist_timeout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (bist_start) state_nxt = S_WAIT_INIT;
            S_WAIT_INIT: if (sdr_init_done)
                             state_nxt = (burst_cnt == 8'd0) ? S_FIN : S_WR;
            S_WR: begin
                if (wd_expire)                  state_nxt = S_FIN;
                else if (beat_ack && last_beat) state_nxt = S_GAP;
            end
            S_GAP:       if (gap_last) state_nxt = S_RD;
            S_RD: begin
                if (wd_expire)                  state_nxt = S_FIN;
                else if (beat_ack && last_beat) state_nxt = S_NEXT;
            end
            S_NEXT:      state_nxt = (burst_cnt == 8'd1) ? S_FIN : S_WR;
            S_FIN:       state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            addr          <= '0;
            burst_addr    <= '0;
            stride        <= '0;
            lfsr          <= 32'h1;
            lfsr_save     <= 32'h1;
            burst_len     <= '0;
            beat_left     <= '0;
            burst_cnt     <= '0;
            gap_cnt       <= '0;
            bist_busy     <= 1'b0;
            bist_done     <= 1'b0;
            bist_pass     <= 1'b0;
            bist_err_cnt  <= '0;
            bist_err_addr <= '0;
        end else begin
            bist_done <= 1'b0;
            case (state)
                S_IDLE: if (bist_start) begin
                    burst_addr    <= cfg_start_addr;
                    stride        <= cfg_addr_stride;
                    burst_len     <= (cfg_burst_len == 5'd0) ? 5'd1 : cfg_burst_len;
                    burst_cnt     <= cfg_num_bursts;
                    lfsr          <= (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
                    bist_err_cnt  <= '0;
                    bist_err_addr <= '0;
                    bist_pass     <= 1'b0;
                    bist_busy     <= 1'b1;
                end
                S_WAIT_INIT: if (state_nxt == S_WR) begin
                    addr      <= burst_addr;
                    lfsr_save <= lfsr;
                    beat_left <= burst_len;
                end
                S_WR: begin
                    gap_cnt <= '0;
                    if (beat_ack) begin
                        addr      <= addr + 30'd1;
                        lfsr      <= lfsr_next;
                        beat_left <= beat_left - 5'd1;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 16'd1;
                    if (gap_last) begin
                        addr      <= burst_addr;
                        lfsr      <= lfsr_save;
                        beat_left <= burst_len;
                    end
                end
                S_RD: if (beat_ack) begin
                    addr      <= addr + 30'd1;
                    lfsr      <= lfsr_next;
                    beat_left <= beat_left - 5'd1;
                    if (wb_dat_i != lfsr) begin
                        if (bist_err_cnt == 16'd0)
                            bist_err_addr <= addr;
                        if (bist_err_cnt != 16'hFFFF)
                            bist_err_cnt <= bist_err_cnt + 16'd1;
                    end
                end
                S_NEXT: begin
                    burst_addr <= burst_addr + stride;
                    burst_cnt  <= burst_cnt - 8'd1;
                    if (state_nxt == S_WR) begin
                        addr      <= burst_addr + stride;
                        lfsr_save <= lfsr;
                        beat_left <= burst_len;
                    end
                end
                S_FIN: begin
                    bist_pass <= (bist_err_cnt == 16'd0) && !bist_timeout;
                    bist_done <= 1'b1;
                    bist_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdrc_wb_bist.sv
// tb/tb_sdrc_wb_bist.sv - Scoreboard bench for sdrc_wb_bist with a zero-wait memory slave.
module tb_sdrc_wb_bist;

    logic        wb_clk_i = 1'b0;
    logic        wb_resetn = 1'b0;
    logic        bist_start = 1'b0;
    logic        sdr_init_done = 1'b1;
    logic [29:0] cfg_start_addr = '0;
    logic [29:0] cfg_addr_stride = '0;
    logic [4:0]  cfg_burst_len = '0;
    logic [7:0]  cfg_num_bursts = '0;
    logic [31:0] cfg_seed = '0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [29:0] wb_addr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;
    logic        bist_busy, bist_done, bist_pass, bist_timeout;
    logic [15:0] bist_err_cnt;
    logic [29:0] bist_err_addr;

    sdrc_wb_bist dut (
        .wb_clk_i(wb_clk_i), .wb_resetn(wb_resetn), .bist_start(bist_start),
        .sdr_init_done(sdr_init_done), .cfg_start_addr(cfg_start_addr),
        .cfg_addr_stride(cfg_addr_stride), .cfg_burst_len(cfg_burst_len),
        .cfg_num_bursts(cfg_num_bursts), .cfg_seed(cfg_seed),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
        .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass),
        .bist_err_cnt(bist_err_cnt), .bist_err_addr(bist_err_addr),
        .bist_timeout(bist_timeout)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [31:0] dat;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       obs_q[$];
    logic [31:0] mem [0:255];
    logic        ack_en = 1'b1;
    int          rd_beat = 0;
    int          corrupt_idx = -1;
    int          stb_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    assign wb_ack_i = wb_stb_o & ack_en;
    assign wb_dat_i = mem[wb_addr_o[7:0]] ^ ((rd_beat == corrupt_idx) ? 32'h1 : 32'h0);

    always @(posedge wb_clk_i) begin
        if (wb_stb_o && wb_ack_i && wb_we_o)
            mem[wb_addr_o[7:0]] <= wb_dat_o;
        if (bist_start && !bist_busy)
            rd_beat <= 0;
        else if (wb_stb_o && wb_ack_i && !wb_we_o)
            rd_beat <= rd_beat + 1;
    end

    always @(negedge wb_clk_i) begin
        if (wb_stb_o) stb_cnt++;
        if (wb_stb_o && wb_ack_i)
            obs_q.push_back('{we: wb_we_o, addr: wb_addr_o, dat: wb_dat_o});
    end

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ ({32{l[0]}} & 32'h80200003);
    endfunction

    task automatic push_run(input logic [29:0] a0, input logic [29:0] strd, input int len,
                            input int nb, input logic [31:0] seed);
        logic [31:0] l;
        logic [29:0] a;
        int n;
        n = (len == 0) ? 1 : len;
        l = (seed == 32'h0) ? 32'h1 : seed;
        a = a0;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back('{we: 1'b1, addr: a + 30'(i), dat: l});
                l = lfsr_step(l);
            end
            for (int i = 0; i < n; i++)
                exp_q.push_back('{we: 1'b0, addr: a + 30'(i), dat: 32'h0});
            a = a + strd;
        end
    endtask

    task automatic pulse_start();
        bist_start = 1'b1;
        @(negedge wb_clk_i);
        bist_start = 1'b0;
    endtask

    task automatic launch(input logic [29:0] a0, input logic [29:0] strd, input int len,
                          input int nb, input logic [31:0] seed);
        cfg_start_addr  = a0;
        cfg_addr_stride = strd;
        cfg_burst_len   = 5'(len);
        cfg_num_bursts  = 8'(nb);
        cfg_seed        = seed;
        exp_q.delete();
        obs_q.delete();
        push_run(a0, strd, len, nb, seed);
        pulse_start();
    endtask

    task automatic wait_done(input string tag, input int limit);
        int c;
        for (c = 0; c < limit; c++) begin
            @(negedge wb_clk_i);
            if (bist_done) break;
        end
        tests++;
        if (c == limit) begin
            fails++;
            $display("FAIL %s done_timeout: no bist_done within %0d cycles", tag, limit);
        end else begin
            tests++;
            if (bist_busy !== 1'b0) begin
                fails++;
                $display("FAIL %s busy_at_done: got %b want 0", tag, bist_busy);
            end
            @(negedge wb_clk_i);
            tests++;
            if (bist_done !== 1'b0) begin
                fails++;
                $display("FAIL %s done_pulse_width: got %b want 0", tag, bist_done);
            end
        end
    endtask

    task automatic check_beats(input string tag);
        beat_t e, o;
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s beat_count: got %0d want %0d", tag, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            tests++;
            if (o.we !== e.we || o.addr !== e.addr || (e.we && o.dat !== e.dat)) begin
                fails++;
                $display("FAIL %s beat: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                         tag, o.we, o.addr, o.dat, e.we, e.addr, e.dat);
            end
        end
    endtask

    task automatic check_status(input string tag, input logic pass, input logic [15:0] ec,
                                input logic [29:0] ea);
        tests++;
        if (bist_pass !== pass || bist_err_cnt !== ec || bist_err_addr !== ea) begin
            fails++;
            $display("FAIL %s status: got pass=%b cnt=%0d addr=%h want pass=%b cnt=%0d addr=%h",
                     tag, bist_pass, bist_err_cnt, bist_err_addr, pass, ec, ea);
        end
    endtask

    task automatic test_reset();
        wb_resetn = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        tests++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o} !== '0) begin
            fails++;
            $display("FAIL reset_bus: got cyc=%b stb=%b we=%b a=%h d=%h sel=%h cti=%h want all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o);
        end
        tests++;
        if ({bist_busy, bist_done, bist_pass, bist_err_cnt, bist_err_addr, bist_timeout} !== '0) begin
            fails++;
            $display("FAIL reset_status: got busy=%b done=%b pass=%b cnt=%h addr=%h to=%b want all 0",
                     bist_busy, bist_done, bist_pass, bist_err_cnt, bist_err_addr, bist_timeout);
        end
        wb_resetn = 1'b1;
        stb_cnt = 0;
        repeat (100) @(negedge wb_clk_i);
        tests++;
        if (stb_cnt !== 0) begin
            fails++;
            $display("FAIL reset_idle_stb: got %0d stb cycles want 0", stb_cnt);
        end
    endtask

    task automatic test_basic();
        launch(30'h10000, 30'h0, 5, 1, 32'h11223344);
        wait_done("basic", 2000);
        check_beats("basic");
        check_status("basic", 1'b1, 16'd0, 30'h0);
    endtask

    task automatic test_corrupt();
        corrupt_idx = 2;
        launch(30'h10000, 30'h0, 5, 1, 32'h11223344);
        wait_done("corrupt", 2000);
        check_beats("corrupt");
        check_status("corrupt", 1'b0, 16'd1, 30'h10002);
        corrupt_idx = -1;
    endtask

    task automatic test_wrap();
        launch(30'h3FFFFFFE, 30'h0, 4, 1, 32'hCAFEF00D);
        wait_done("wrap", 2000);
        check_beats("wrap");
        check_status("wrap", 1'b1, 16'd0, 30'h0);
    endtask

    task automatic test_multi_burst();
        launch(30'h40, 30'h10, 0, 3, 32'h0);
        wait_done("multi_len0", 2000);
        check_beats("multi_len0");
        check_status("multi_len0", 1'b1, 16'd0, 30'h0);
        launch(30'h3FFFFFFC, 30'h8, 3, 2, 32'hDEADBEEF);
        wait_done("multi_stride_wrap", 2000);
        check_beats("multi_stride_wrap");
        check_status("multi_stride_wrap", 1'b1, 16'd0, 30'h0);
    endtask

    task automatic test_init_and_busy();
        int c;
        sdr_init_done = 1'b0;
        stb_cnt = 0;
        launch(30'h20, 30'h0, 2, 1, 32'h5A5A5A5A);
        repeat (20) @(negedge wb_clk_i);
        tests++;
        if (stb_cnt !== 0 || bist_busy !== 1'b1) begin
            fails++;
            $display("FAIL init_wait: got stb_cycles=%0d busy=%b want 0 and 1", stb_cnt, bist_busy);
        end
        cfg_start_addr = 30'h80;
        cfg_num_bursts = 8'd5;
        pulse_start();
        repeat (3) @(negedge wb_clk_i);
        sdr_init_done = 1'b1;
        wait_done("busy_restart", 2000);
        check_beats("busy_restart");
        check_status("busy_restart", 1'b1, 16'd0, 30'h0);
        launch(30'h0, 30'h0, 4, 0, 32'h1);
        for (c = 0; c < 3; c++) begin
            @(negedge wb_clk_i);
            if (bist_done) break;
        end
        tests++;
        if (c == 3 || bist_pass !== 1'b1) begin
            fails++;
            $display("FAIL empty_run: got done_seen=%0d pass=%b want 1 and 1", (c < 3), bist_pass);
        end
        check_beats("empty_run");
    endtask

    task automatic test_reset_mid_burst();
        launch(30'h0, 30'h0, 31, 4, 32'h77);
        repeat (4) @(negedge wb_clk_i);
        wb_resetn = 1'b0;
        #1;
        tests++;
        if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0 || bist_busy !== 1'b0 || bist_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got stb=%b cyc=%b busy=%b done=%b want all 0",
                     wb_stb_o, wb_cyc_o, bist_busy, bist_done);
        end
        @(negedge wb_clk_i);
        wb_resetn = 1'b1;
        @(negedge wb_clk_i);
        exp_q.delete();
        obs_q.delete();
    endtask

`ifdef SDRC_BIST_TIMEOUT_EN
    task automatic test_timeout();
        ack_en = 1'b0;
        stb_cnt = 0;
        launch(30'h100, 30'h0, 4, 1, 32'h9);
        wait_done("timeout", 1000);
        tests++;
        if (stb_cnt !== 256 || bist_timeout !== 1'b1 || bist_pass !== 1'b0) begin
            fails++;
            $display("FAIL timeout: got stb_cycles=%0d timeout=%b pass=%b want 256 1 0",
                     stb_cnt, bist_timeout, bist_pass);
        end
        ack_en = 1'b1;
        exp_q.delete();
        obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_corrupt();
        test_wrap();
        test_multi_burst();
        test_init_and_busy();
        test_reset_mid_burst();
`ifdef SDRC_BIST_TIMEOUT_EN
        test_timeout();
`endif
        test_basic();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
